// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// memory geometry and the word driven to the CPU while no program is valid.
package prog_loader_pkg;

  localparam int WORDS_DEF = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  localparam logic [DATA_W-1:0] NOP_WORD = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ARMED,
    RUN,
    FAIL
  } state_e;

endpackage

// File: rtl/prog_ram_16x8.sv
// Program store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a reset never disturbs the image.
module prog_ram_16x8
  import prog_loader_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/prog_loader.sv
// Loads a program image from a byte stream into the instruction RAM and gates
// the CPU clock-enable. Define PROG_LOADER_CKSUM_EN to require a trailing checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORDS    = WORDS_DEF,
  parameter int AUTO_RUN = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic              GO,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic [ADDR_W-1:0] RD_AD,
  output logic [DATA_W-1:0] RD_Q,
  output logic              CPU_RUN,
  output logic              BUSY,
  output logic              LOAD_DONE,
  output logic              ERR
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(WORDS - 1);
  localparam state_e            DONE_ST  = (AUTO_RUN != 0) ? RUN : ARMED;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] sum_q;
  logic              load_done_q;
  logic [DATA_W-1:0] ram_rd;
  logic              ram_we;

  // A restart or reset in the same cycle as a byte discards that byte.
  assign ram_we = (state_q == LOAD) && DIN_VALID && !START && !RST;

`ifdef PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0] cksum_total;
  assign cksum_total = sum_q + DIN;
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sum_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (START) begin
        state_q <= LOAD;
        ptr_q   <= '0;
        sum_q   <= '0;
      end else begin
        case (state_q)
          LOAD: begin
            if (DIN_VALID) begin
              sum_q <= sum_q + DIN;
              if (ptr_q == LAST_PTR) begin
                ptr_q <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                state_q <= CHECK;
`else
                state_q     <= DONE_ST;
                load_done_q <= 1'b1;
`endif
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end
          end
`ifdef PROG_LOADER_CKSUM_EN
          CHECK: begin
            if (DIN_VALID) begin
              if (cksum_total == 8'h00) begin
                state_q     <= DONE_ST;
                load_done_q <= 1'b1;
              end else begin
                state_q <= FAIL;
              end
            end
          end
`endif
          ARMED: begin
            if (GO) begin
              state_q <= RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  prog_ram_16x8 #(
    .WORDS(WORDS)
  ) u_ram (
    .clk_i(CK),
    .we_i (ram_we),
    .wa_i (ptr_q),
    .wd_i (DIN),
    .ra_i (RD_AD),
    .rd_o (ram_rd)
  );

  // Outputs are a pure decode of the registered state.
  assign DIN_READY = (state_q == LOAD) || (state_q == CHECK);
  assign BUSY      = DIN_READY;
  assign CPU_RUN   = (state_q == RUN);
  assign LOAD_DONE = load_done_q;
  assign RD_Q      = ((state_q == ARMED) || (state_q == RUN)) ? ram_rd : NOP_WORD;

`ifdef PROG_LOADER_CKSUM_EN
  assign ERR = (state_q == FAIL);
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: one AUTO_RUN=1 and one AUTO_RUN=0 instance
// share stimulus; a byte-counting reference model predicts every cycle's outputs.
module tb_prog_loader;

`ifdef PROG_LOADER_CKSUM_EN
  localparam int NB    = 17;
  localparam bit CK_EN = 1'b1;
`else
  localparam int NB    = 16;
  localparam bit CK_EN = 1'b0;
`endif

  localparam int M_IDLE    = 0;
  localparam int M_LOADING = 1;
  localparam int M_ARMED   = 2;
  localparam int M_RUN     = 3;
  localparam int M_ERROR   = 4;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       cpu_run;
    logic       done;
    logic       err;
    logic [7:0] rd_q;
  } obs_t;

  logic       ck = 1'b0;
  logic       rst, start, go, vld;
  logic [7:0] din;
  logic [3:0] rd_ad;

  logic       rdy_a, run_a, busy_a, done_a, err_a;
  logic [7:0] rdq_a;
  logic       rdy_b, run_b, busy_b, done_b, err_b;
  logic [7:0] rdq_b;

  always #5 ck = ~ck;

  prog_loader #(.WORDS(16), .AUTO_RUN(1)) u_dut_auto (
    .CK(ck), .RST(rst), .START(start), .GO(go), .DIN(din), .DIN_VALID(vld),
    .DIN_READY(rdy_a), .RD_AD(rd_ad), .RD_Q(rdq_a), .CPU_RUN(run_a),
    .BUSY(busy_a), .LOAD_DONE(done_a), .ERR(err_a)
  );

  prog_loader #(.WORDS(16), .AUTO_RUN(0)) u_dut_armed (
    .CK(ck), .RST(rst), .START(start), .GO(go), .DIN(din), .DIN_VALID(vld),
    .DIN_READY(rdy_b), .RD_AD(rd_ad), .RD_Q(rdq_b), .CPU_RUN(run_b),
    .BUSY(busy_b), .LOAD_DONE(done_b), .ERR(err_b)
  );

  // Reference model: index 0 follows the auto-run instance, index 1 the armed one.
  int         mode [2];
  int         cnt  [2];
  logic [7:0] sum  [2];
  logic [7:0] img  [2][16];
  bit         done [2];
  bit         known = 1'b0;

  obs_t exp_q [2][$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  logic [7:0] pat [17];

  task automatic model_step(input int k);
    done[k] = 1'b0;
    if (rst) begin
      mode[k] = M_IDLE;
      cnt[k]  = 0;
      sum[k]  = 8'h00;
    end else if (start) begin
      mode[k] = M_LOADING;
      cnt[k]  = 0;
      sum[k]  = 8'h00;
    end else if (mode[k] == M_LOADING && vld) begin
      if (cnt[k] < 16) img[k][cnt[k]] = din;
      sum[k] = sum[k] + din;
      cnt[k] = cnt[k] + 1;
      if (cnt[k] == NB) begin
        if (!CK_EN || sum[k] == 8'h00) begin
          mode[k] = (k == 0) ? M_RUN : M_ARMED;
          done[k] = 1'b1;
        end else begin
          mode[k] = M_ERROR;
        end
      end
    end else if (mode[k] == M_ARMED && go) begin
      mode[k] = M_RUN;
    end
  endtask

  function automatic obs_t predict(input int k);
    obs_t o;
    o.ready   = (mode[k] == M_LOADING);
    o.busy    = (mode[k] == M_LOADING);
    o.cpu_run = (mode[k] == M_RUN);
    o.done    = done[k];
    o.err     = (mode[k] == M_ERROR);
    o.rd_q    = (mode[k] == M_ARMED || mode[k] == M_RUN) ? img[k][rd_ad] : 8'h00;
    return o;
  endfunction

  // Apply one cycle of inputs; expectations for this cycle go to the scoreboard.
  task automatic tick(input logic r, input logic s, input logic g, input logic v,
                      input logic [7:0] d, input logic [3:0] a);
    rst = r; start = s; go = g; vld = v; din = d; rd_ad = a;
    if (known) begin
      exp_q[0].push_back(predict(0));
      exp_q[1].push_back(predict(1));
    end
    @(posedge ck);
    model_step(0);
    model_step(1);
    if (r) known = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 8'($urandom), 4'($urandom));
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) tick(0, 0, 0, 0, 8'h00, 4'(a));
  endtask

  task automatic send_pat(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) tick(0, 0, 0, 0, 8'($urandom), 4'($urandom));
      tick(0, 0, 0, 1, pat[i], 4'($urandom));
    end
  endtask

  task automatic rand_pat(input bit good);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      pat[i] = 8'($urandom);
      s = s + pat[i];
    end
    pat[16] = good ? 8'h00 - s : 8'h01 - s;
  endtask

  task automatic check(input int k, input obs_t act);
    obs_t e;
    e = exp_q[k].pop_front();
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL outputs inst%0d cyc%0d: got ready=%b busy=%b run=%b done=%b err=%b rd_q=%h, required ready=%b busy=%b run=%b done=%b err=%b rd_q=%h",
               k, cyc, act.ready, act.busy, act.cpu_run, act.done, act.err, act.rd_q,
               e.ready, e.busy, e.cpu_run, e.done, e.err, e.rd_q);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge ck);
      cyc++;
      if (exp_q[0].size() > 0) check(0, '{rdy_a, busy_a, run_a, done_a, err_a, rdq_a});
      if (exp_q[1].size() > 0) check(1, '{rdy_b, busy_b, run_b, done_b, err_b, rdq_b});
    end
  end

  initial begin : stimulus
    logic [7:0] d;
    logic r, s, g, v;

    tick(1, 0, 0, 0, 8'h00, 4'h0);
    tick(1, 1, 1, 1, 8'h55, 4'h0);
    tick(0, 0, 1, 0, 8'h00, 4'h0);
    idle(2);

    // Bytes 0x01..0x10 (sum 0x88), good checksum 0x78 when enabled.
    for (int i = 0; i < 16; i++) pat[i] = 8'(i + 1);
    pat[16] = 8'h78;
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    send_pat(NB, 1'b0);
    tick(0, 0, 0, 0, 8'h00, 4'd3);
    read_all();
    tick(0, 0, 1, 0, 8'h00, 4'd3);
    read_all();

    // Same image with bad checksum 0x77.
    pat[16] = 8'h77;
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    send_pat(NB, 1'b0);
    read_all();
    tick(0, 0, 1, 0, 8'h00, 4'd3);
    idle(3);

    // DIN_VALID toggling every other cycle, then extra VALID with no READY.
    rand_pat(1'b1);
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    send_pat(NB, 1'b1);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 8'($urandom), 4'(i));
    read_all();
    tick(0, 0, 1, 0, 8'h00, 4'h0);
    read_all();

    // Reset after byte 7, then a full reload from address 0.
    rand_pat(1'b1);
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    send_pat(7, 1'b0);
    tick(1, 1, 1, 1, 8'hAA, 4'h0);
    idle(2);
    rand_pat(1'b1);
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    send_pat(NB, 1'b0);
    read_all();

    // START while running.
    tick(0, 1, 0, 0, 8'h00, 4'h0);
    idle(3);

    // Randomized traffic; usually complete the checksum so loads succeed.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 79) == 0);
      g = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if (CK_EN && mode[0] == M_LOADING && cnt[0] == 16 && $urandom_range(0, 3) != 0)
        d = 8'h00 - sum[0];
      tick(r, s, g, v, d, 4'($urandom));
    end

    idle(1);
    repeat (2) @(negedge ck);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WORDS, default 16, number of 8-bit instruction words (address width 4).
REQ-002 SHALL have parameter AUTO_RUN, default 1, where 1 raises CPU_RUN after a good load and 0 holds CPU_RUN low until GO.
REQ-003 SHALL provide port CK, input, 1, the single clock; one clock; all state updates on posedge CK.
REQ-004 SHALL provide port RST, input, 1, synchronous active-high reset sampled on posedge CK.
REQ-005 SHALL provide port START, input, 1, a level pulse that begins a program load.
REQ-006 SHALL provide port GO, input, 1, which releases the CPU when AUTO_RUN=0.
REQ-007 SHALL provide port DIN, input, 8, the program byte from the host.
REQ-008 SHALL provide port DIN_VALID, input, 1, qualifying DIN.
REQ-009 SHALL provide port DIN_READY, output, 1, the loader accepts DIN this cycle.
REQ-010 SHALL provide port RD_AD, input, 4, the CPU fetch address from the program counter.
REQ-011 SHALL provide port RD_Q, output, 8, the instruction word to the CPU (opcode [7:4], immediate [3:0]).
REQ-012 SHALL provide port CPU_RUN, output, 1, the CPU clock-enable, high only when the program is valid.
REQ-013 SHALL provide port BUSY, output, 1, which is high in LOAD or CHECK.
REQ-014 SHALL provide port LOAD_DONE, output, 1, a one-cycle pulse when a load completes successfully.
REQ-015 SHALL provide port ERR, output, 1, a checksum failure flag.

Function
REQ-016 SHALL have states IDLE, LOAD, CHECK, ARMED, RUN, FAIL.
REQ-017 SHALL go IDLE->LOAD on START; in ARMED/RUN/FAIL START also goes to LOAD; START in LOAD/CHECK restarts: pointer=0, stay LOAD.
REQ-018 SHALL assert DIN_READY=1 only in LOAD and CHECK; a transfer occurs when DIN_VALID&DIN_READY.
REQ-019 SHALL, on each LOAD transfer, write DIN to mem[ptr], ptr+=1, and add DIN into an 8-bit running sum (mod 256); the sum clears on entry to LOAD.
REQ-020 SHALL, on the transfer with ptr=WORDS-1, make ptr wrap to 0 and move next to CHECK (if checksum compiled in) else to ARMED/RUN.
REQ-021 SHALL, in CHECK, treat one transfer as a checksum byte: if (sum+DIN) mod 256 == 0, go to ARMED/RUN; else go to FAIL.
REQ-022 SHALL go to RUN if AUTO_RUN=1, else to ARMED; ARMED->RUN on GO; GO is ignored outside ARMED.
REQ-023 SHALL pulse LOAD_DONE for exactly the cycle after the final accepted byte (entry to ARMED or RUN).
REQ-024 SHALL drive CPU_RUN=1 only in RUN, beginning the cycle after the last byte (AUTO_RUN=1) or after GO.
REQ-025 SHALL set RD_Q=mem[RD_AD] combinationally in ARMED/RUN and 8'h00 in all other states; a write is visible on RD_Q from the next cycle.
REQ-026 SHALL hold ERR=1 only in FAIL, where CPU_RUN=0; only START or RST leaves FAIL.
REQ-027 SHALL leave DIN_VALID without READY with no effect; a DIN_VALID gap mid-load SHALL hold the state indefinitely (no timeout).

Reset
REQ-028 SHALL, on RST, set state=IDLE, ptr=0, sum=0, CPU_RUN=0, BUSY=0, LOAD_DONE=0, ERR=0, DIN_READY=0, RD_Q=8'h00.
REQ-029 SHALL not clear memory contents on RST; RST mid-load abandons the load and the partial image is never executed (CPU_RUN stays 0 until a full load).
REQ-030 SHALL let RST win over START/GO/DIN_VALID in the same cycle.

Configuration
REQ-031 SHALL, when macro PROG_LOADER_CKSUM_EN is defined, compile in the CHECK state and FAIL state, with 17 bytes per load.
REQ-032 SHALL, when the macro is undefined, compile out CHECK and FAIL, tie ERR=0, and use 16 bytes per load.

Structure
REQ-033 SHALL place the state enum, WORDS_DEF=16, ADDR_W=4, DATA_W=8 and NOP_WORD=8'h00 in shared package prog_loader_pkg.
REQ-034 SHALL use one sub-module prog_ram_16x8 (one synchronous write port, one asynchronous read port, no reset); the FSM, pointer and checksum stay in prog_loader.

Verification
REQ-035 SHALL cover: RST, START, 16 bytes 8'h01..8'h10 with continuous VALID (macro off) -> LOAD_DONE one cycle later, CPU_RUN=1, RD_AD=4'd3 gives RD_Q=8'h04.
REQ-036 SHALL cover: macro on, 16 bytes summing to 8'h88 then checksum 8'h78 -> RUN, ERR=0; repeat with checksum 8'h77 -> FAIL, ERR=1, CPU_RUN=0, RD_Q=8'h00.
REQ-037 SHALL cover: DIN_VALID toggling every other cycle -> exactly 16 writes, ptr wraps to 0, no extra write.
REQ-038 SHALL cover: RST after byte 7 -> IDLE, CPU_RUN=0, DIN_READY=0; a new START reloads from address 0.
REQ-039 SHALL cover: AUTO_RUN=0 -> ARMED after the load with CPU_RUN=0; GO -> CPU_RUN=1 next cycle; GO in IDLE -> no effect.
REQ-040 SHALL cover: START asserted in RUN -> CPU_RUN=0 next cycle, BUSY=1, ptr=0.
